// File: rtl/elevator_car_request_panel_if.sv
// Request handshake between the car request panel (master) and the car request queue (slave).
interface elevator_car_request_panel_if #(
  parameter int unsigned NUM_FLOORS = 8
);
  localparam int unsigned FLOOR_W = $clog2(NUM_FLOORS);

  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_ready;

  modport master (output req_valid, output req_floor, input req_ready);
  modport slave  (input req_valid, input req_floor, output req_ready);
endinterface

// File: rtl/elevator_car_request_panel.sv
// In-car floor request panel: synchronise and debounce the buttons, latch one-shot
// pending requests, offer them round-robin over a valid/ready handshake and drive lamps.
// Optional feature macro: ELEVATOR_PANEL_SKIP_CURRENT_EN (drop presses of current_floor).
module elevator_car_request_panel #(
  parameter int unsigned NUM_FLOORS      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  localparam int unsigned FLOOR_W        = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] buttons,
  input  logic [NUM_FLOORS-1:0] queue_status,
  input  logic [FLOOR_W-1:0]    current_floor,
  elevator_car_request_panel_if.master req_if,
  output logic [NUM_FLOORS-1:0] button_panel_light
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, OFFER} state_e;

  logic [NUM_FLOORS-1:0] sync1_q, sync2_q;
  logic [NUM_FLOORS-1:0] deb_q, deb_d, deb_prev_q;
  logic [CNT_W-1:0]      cnt_q [NUM_FLOORS];
  logic [CNT_W-1:0]      cnt_d [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] rise_c, offer_oh_c, skip_c, set_c, clr_c;
  logic [FLOOR_W-1:0]    rr_q, rr_d;
  logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
  logic                  req_valid_q, req_valid_d;
  logic [FLOOR_W-1:0]    pick_c;
  logic                  found_c;
  int unsigned           idx_c;
  state_e                state_q, state_d;

  // Two-flop synchroniser for the raw asynchronous buttons.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a synced level must differ from the accepted level for DEBOUNCE_CYCLES cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and previous debounced level for rise detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NUM_FLOORS; i++) cnt_q[i] <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NUM_FLOORS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Press filtering: only rising edges count, minus floors already queued or on offer.
  always_comb begin
    rise_c     = deb_q & ~deb_prev_q;
    offer_oh_c = '0;
    skip_c     = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      offer_oh_c[i] = req_valid_q && (req_floor_q == FLOOR_W'(i));
`ifdef ELEVATOR_PANEL_SKIP_CURRENT_EN
      skip_c[i]     = (current_floor == FLOOR_W'(i));
`endif
    end
    set_c = rise_c & ~queue_status & ~offer_oh_c & ~skip_c;
  end

`ifndef ELEVATOR_PANEL_SKIP_CURRENT_EN
  logic unused_current_floor;
  assign unused_current_floor = ^current_floor;
`endif

  // Round-robin pick: first pending floor at or after rr_ptr, wrapping at NUM_FLOORS.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    idx_c   = 0;
    for (int unsigned k = 0; k < NUM_FLOORS; k++) begin
      idx_c = (32'(rr_q) + k) % NUM_FLOORS;
      if (!found_c && pending_q[FLOOR_W'(idx_c)]) begin
        found_c = 1'b1;
        pick_c  = FLOOR_W'(idx_c);
      end
    end
  end

  // Offer FSM next state; a picked floor leaves pending as it goes on offer.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_floor_d = req_floor_q;
    rr_d        = rr_q;
    clr_c       = '0;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          req_valid_d = 1'b1;
          req_floor_d = pick_c;
          clr_c       = NUM_FLOORS'(1) << pick_c;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (req_if.req_ready) begin
          req_valid_d = 1'b0;
          rr_d        = (req_floor_q == FLOOR_W'(NUM_FLOORS - 1)) ? '0
                                                                  : req_floor_q + FLOOR_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q | set_c) & ~clr_c;
  end

  // FSM, pending set and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_floor_q <= '0;
      rr_q        <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_floor_q <= req_floor_d;
      rr_q        <= rr_d;
      pending_q   <= pending_d;
    end
  end

  assign req_if.req_valid   = req_valid_q;
  assign req_if.req_floor   = req_floor_q;
  assign button_panel_light = queue_status | pending_q | offer_oh_c;

endmodule

// File: tb/tb_elevator_car_request_panel.sv
// Directed bench for elevator_car_request_panel (NUM_FLOORS=8, DEBOUNCE_CYCLES=4).
module tb_elevator_car_request_panel;
  localparam int unsigned N = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] buttons;
  logic [7:0] queue_status;
  logic [2:0] current_floor;
  logic [7:0] light;
  logic [2:0] got [$];
  int         checks = 0;
  int         errors = 0;
  bit         ok;

  always #5 clk = ~clk;

  elevator_car_request_panel_if #(.NUM_FLOORS(N)) req_if ();

  elevator_car_request_panel #(.NUM_FLOORS(N), .DEBOUNCE_CYCLES(4)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .buttons            (buttons),
    .queue_status       (queue_status),
    .current_floor      (current_floor),
    .req_if             (req_if.master),
    .button_panel_light (light)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Collect every floor accepted (valid & ready) over n cycles.
  task automatic record(input int n);
    got.delete();
    repeat (n) begin
      if (req_if.req_valid && req_if.req_ready) got.push_back(req_if.req_floor);
      tick(1);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (got.size() > i) ? 32'(got[i]) : 32'hdead;
  endfunction

  task automatic wait_valid(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (req_if.req_valid) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    bit any = 1'b0;
    repeat (n) begin
      if (req_if.req_valid) any = 1'b1;
      tick(1);
    end
    chk(tag, 32'(any), 32'd0);
  endtask

  task automatic hold_check(input string tag, input int n);
    repeat (n) begin
      chk(tag, 32'({req_if.req_valid, req_if.req_floor}), 32'h9);
      tick(1);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    buttons          = '0;
    queue_status     = 8'h10;
    current_floor    = 3'd4;
    req_if.req_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(req_if.req_valid), 32'd0);
    chk("rst_floor", 32'(req_if.req_floor), 32'd0);
    chk("rst_light_qs", 32'(light), 32'h10);
    queue_status = '0;
    #1;
    chk("rst_light_zero", 32'(light), 32'h0);
    tick(2);
    reset_n = 1'b1;

    // 1: single held press, latency and one-shot behaviour
    buttons = 8'h04;
    tick(7);
    chk("t1_no_valid_e7", 32'(req_if.req_valid), 32'd0);
    chk("t1_pend_light", 32'(light), 32'h04);
    tick(1);
    chk("t1_valid_e8", 32'(req_if.req_valid), 32'd1);
    chk("t1_floor_e8", 32'(req_if.req_floor), 32'd2);
    chk("t1_offer_light", 32'(light), 32'h04);
    record(20);
    chk("t1_count", 32'(got.size()), 32'd1);
    chk("t1_floor", got_at(0), 32'd2);
    chk("t1_light_after", 32'(light), 32'h0);
    buttons = '0;
    tick(10);

    // 2: bounce on floor 5 never passes the debouncer
    buttons = 8'h20; tick(1);
    buttons = 8'h00; tick(1);
    buttons = 8'h20; tick(1);
    buttons = 8'h00;
    idle_check("t2_no_req", 15);
    chk("t2_light", 32'(light), 32'h0);

    // 3: simultaneous presses served round-robin, pointer lands on 6
    do_reset();
    buttons = 8'h29;
    tick(7);
    chk("t3_pend_light", 32'(light), 32'h29);
    record(12);
    chk("t3_count", 32'(got.size()), 32'd3);
    chk("t3_first", got_at(0), 32'd0);
    chk("t3_second", got_at(1), 32'd3);
    chk("t3_third", got_at(2), 32'd5);
    buttons = '0;
    tick(10);
    buttons = 8'h84;
    record(20);
    chk("t3_rr_count", 32'(got.size()), 32'd2);
    chk("t3_rr_first7", got_at(0), 32'd7);
    chk("t3_rr_wrap2", got_at(1), 32'd2);
    buttons = '0;
    tick(10);

    // 4: stalled offer holds stable; re-press of offered floor dropped, other floor kept
    req_if.req_ready = 1'b0;
    buttons = 8'h02;
    wait_valid(20, ok);
    chk("t4_valid_seen", 32'(ok), 32'd1);
    chk("t4_floor", 32'(req_if.req_floor), 32'd1);
    buttons = '0;
    hold_check("t4_hold_a", 8);
    buttons = 8'h42;
    hold_check("t4_hold_b", 10);
    chk("t4_light", 32'(light), 32'h42);
    req_if.req_ready = 1'b1;
    record(15);
    chk("t4_count", 32'(got.size()), 32'd2);
    chk("t4_first", got_at(0), 32'd1);
    chk("t4_second", got_at(1), 32'd6);
    buttons = '0;
    tick(10);
    chk("t4_light_after", 32'(light), 32'h0);

    // 5: already queued floor dropped but lit; current floor handling
    queue_status = 8'h10;
    buttons = 8'h10;
    idle_check("t5_queued_no_req", 15);
    chk("t5_queued_light", 32'(light), 32'h10);
    buttons = '0;
    tick(10);
    queue_status = '0;
    tick(1);
    chk("t5_light_clear", 32'(light), 32'h0);
    current_floor = 3'd3;
    buttons = 8'h08;
`ifdef ELEVATOR_PANEL_SKIP_CURRENT_EN
    idle_check("t5_cur_no_req", 15);
    chk("t5_cur_light", 32'(light), 32'h0);
`else
    record(15);
    chk("t5_cur_count", 32'(got.size()), 32'd1);
    chk("t5_cur_floor", got_at(0), 32'd3);
`endif
    buttons = '0;
    tick(10);
    current_floor = 3'd4;

    // 6: reset during an offer clears everything at once; fresh presses start from rr=0
    req_if.req_ready = 1'b0;
    buttons = 8'h40;
    wait_valid(20, ok);
    chk("t6_valid_seen", 32'(ok), 32'd1);
    chk("t6_floor", 32'(req_if.req_floor), 32'd6);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(req_if.req_valid), 32'd0);
    chk("t6_rst_floor", 32'(req_if.req_floor), 32'd0);
    chk("t6_rst_light", 32'(light), 32'h0);
    buttons = '0;
    tick(2);
    reset_n = 1'b1;
    buttons = 8'h42;
    req_if.req_ready = 1'b1;
    record(20);
    chk("t6_count", 32'(got.size()), 32'd2);
    chk("t6_first", got_at(0), 32'd1);
    chk("t6_second", got_at(1), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
